pipe_mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, between the EX/MEM register and the MEM/WB register. Runs loads and stores over a req/ack data-memory port and aligns store data and byte enables. Sign- or zero-extends load data, detects misalignment, and stalls the front of the pipe until memory answers. Its outputs drive the MEM/WB register inputs directly; while stalled it presents a bubble.

---
 rtl/pipe_mem_stage.sv | 165 ++++++++++++++++
 tb/tb_pipe_mem_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// Memory-access stage: issues loads/stores on a req/ack data port, aligns
// store data and byte enables, extends load data and stalls the front of
// the pipe until memory answers.
module pipe_mem_stage (
    input  logic        clk,
    input  logic        clr,
    input  logic        mvalid,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        msign,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        owreg,
    output logic        om2reg,
    output logic [31:0] oalu,
    output logic [4:0]  orn,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        mexc,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    input  logic        d_ack
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic [1:0]  off_q, off_d;

    logic        memop, is_load, misaligned, aligned_op;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    // Decode the presented instruction and build the aligned bus lanes.
    always_comb begin
        memop      = mvalid & (mm2reg | mwmem);
        is_load    = memop & mm2reg;
        misaligned = memop & (((msize == 2'b01) & malu[0]) | (msize[1] & (|malu[1:0])));
        aligned_op = memop & ~misaligned;
        case (msize)
            2'b00: begin
                be_new    = 4'b0001 << malu[1:0];
                wdata_new = {4{mb[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << malu[1:0];
                wdata_new = {2{mb[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = mb;
            end
        endcase
    end

    // Next-state logic for the bus FSM and its latched bus fields.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        off_d   = off_q;
        case (state_q)
            StIdle: begin
                if (aligned_op) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    // Load wins when both load and store flags are set.
                    we_d    = mwmem & ~mm2reg;
                    addr_d  = {malu[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    off_d   = malu[1:0];
                end
            end
            StBusy: begin
                if (d_ack) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        load_d = d_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and bus registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            off_q   <= off_d;
        end
    end

    // Load-data extraction and stage outputs towards MEM/WB.
    always_comb begin
        logic [7:0]  lb;
        logic [15:0] lh;
        case (off_q)
            2'd0:    lb = load_q[7:0];
            2'd1:    lb = load_q[15:8];
            2'd2:    lb = load_q[23:16];
            default: lb = load_q[31:24];
        endcase
        lh = off_q[1] ? load_q[31:16] : load_q[15:0];
        case (msize)
            2'b00:   mmo = {{24{msign & lb[7]}}, lb};
            2'b01:   mmo = {{16{msign & lh[15]}}, lh};
            default: mmo = load_q;
        endcase
        if (!is_load) begin
            mmo = '0;
        end
        mstall  = aligned_op & (state_q != StDone);
        owreg   = mwreg & mvalid & ~mstall & ~misaligned;
        om2reg  = mm2reg & owreg;
        mexc    = misaligned;
        oalu    = malu;
        orn     = mrn;
        d_req   = req_q;
        d_we    = we_q;
        d_addr  = addr_q;
        d_be    = be_q;
        d_wdata = wdata_q;
    end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Randomized self-checking bench for pipe_mem_stage against a
// transaction-level model of the memory stage.
module tb_pipe_mem_stage;

    logic        clk = 1'b0;
    logic        clr, mvalid, mwreg, mm2reg, mwmem, msign;
    logic [1:0]  msize;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        owreg, om2reg, mstall, mexc, d_req, d_we, d_ack;
    logic [31:0] oalu, mmo, d_addr, d_wdata, d_rdata;
    logic [4:0]  orn;
    logic [3:0]  d_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_mem_stage dut (
        .clk(clk), .clr(clr), .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg),
        .mwmem(mwmem), .msize(msize), .msign(msign), .malu(malu), .mb(mb), .mrn(mrn),
        .owreg(owreg), .om2reg(om2reg), .oalu(oalu), .orn(orn), .mmo(mmo),
        .mstall(mstall), .mexc(mexc), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction and follow it to completion; wt = ack-wait cycles.
    task automatic run_op(input logic v, input logic wr, input logic l, input logic s,
                          input logic [1:0] sz, input logic sg, input logic [31:0] alu,
                          input logic [31:0] b, input logic [4:0] rn, input int wt,
                          input logic [31:0] rd);
        logic        memop, mis, ld;
        int          off;
        logic [3:0]  be;
        logic [31:0] wd, mo, ea;
        int          stalls;
        memop = v & (l | s);
        off   = int'(alu[1:0]);
        mis   = memop && ((sz == 2'd1 && alu[0]) || (sz >= 2'd2 && off != 0));
        ld    = memop & l;
        ea    = alu - 32'(off);
        if (sz == 2'd0) begin
            be = 4'(1 << off);
            wd = {24'h0, b[7:0]} * 32'h0101_0101;
            mo = (rd >> (8 * off)) & 32'hFF;
            if (sg && mo[7]) mo = mo | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            be = 4'(3 << off);
            wd = {16'h0, b[15:0]} * 32'h0001_0001;
            mo = (rd >> (8 * off)) & 32'hFFFF;
            if (sg && mo[15]) mo = mo | 32'hFFFF_0000;
        end else begin
            be = 4'hF;
            wd = b;
            mo = rd;
        end
        if (!ld) mo = 32'h0;

        @(posedge clk); #1;
        mvalid = v; mwreg = wr; mm2reg = l; mwmem = s; msize = sz; msign = sg;
        malu = alu; mb = b; mrn = rn;
        d_ack = 1'($urandom_range(0, 1));
        d_rdata = $urandom;
        @(negedge clk);
        stalls = int'(mstall);
        check_eq("first_req", 32'(d_req), 32'h0);
        check_eq("first_mexc", 32'(mexc), 32'(mis));
        check_eq("oalu", oalu, alu);
        check_eq("orn", 32'(orn), 32'(rn));
        if (memop && !mis) begin
            check_eq("first_stall", 32'(mstall), 32'h1);
            check_eq("first_owreg", 32'(owreg), 32'h0);
            for (int k = 0; k <= wt; k++) begin
                @(posedge clk); #1;
                d_ack = (k == wt);
                d_rdata = (k == wt) ? rd : $urandom;
                @(negedge clk);
                stalls += int'(mstall);
                check_eq("busy_req", 32'(d_req), 32'h1);
                check_eq("busy_we", 32'(d_we), 32'(s & ~l));
                check_eq("busy_addr", d_addr, ea);
                check_eq("busy_be", 32'(d_be), 32'(be));
                check_eq("busy_wdata", d_wdata, wd);
            end
            @(posedge clk); #1;
            d_ack = 1'($urandom_range(0, 1));
            d_rdata = $urandom;
            @(negedge clk);
            stalls += int'(mstall);
            check_eq("done_stall", 32'(mstall), 32'h0);
            check_eq("done_req", 32'(d_req), 32'h0);
            check_eq("done_owreg", 32'(owreg), 32'(wr));
            check_eq("done_om2reg", 32'(om2reg), 32'(wr & l));
            check_eq("done_mmo", mmo, mo);
            check_eq("stall_cycles", 32'(stalls), 32'(wt + 2));
        end else begin
            check_eq("nomem_stall", 32'(mstall), 32'h0);
            check_eq("nomem_owreg", 32'(owreg), 32'(wr & v & ~mis));
            check_eq("nomem_om2reg", 32'(om2reg), 32'(wr & v & ~mis & l));
            if (!ld) check_eq("nomem_mmo", mmo, 32'h0);
        end
    endtask

    initial begin
        clr = 1'b1; mvalid = 0; mwreg = 0; mm2reg = 0; mwmem = 0; msize = 0; msign = 0;
        malu = 0; mb = 0; mrn = 0; d_ack = 0; d_rdata = 0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check_eq("rst_req", 32'(d_req), 32'h0);
        check_eq("rst_we", 32'(d_we), 32'h0);
        check_eq("rst_addr", d_addr, 32'h0);
        check_eq("rst_be", 32'(d_be), 32'h0);
        check_eq("rst_wdata", d_wdata, 32'h0);
        check_eq("rst_mexc", 32'(mexc), 32'h0);
        check_eq("rst_owreg", 32'(owreg), 32'h0);

        // Directed cases.
        run_op(1, 1, 0, 0, 2'd2, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        run_op(1, 1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd7, 0, 32'h8012_3456);
        run_op(1, 0, 0, 1, 2'd1, 0, 32'h202, 32'hABCD, 5'd0, 3, 32'h0);
        run_op(1, 1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd3, 0, 32'h0);
        run_op(1, 1, 1, 0, 2'd1, 0, 32'h2, 32'h0, 5'd9, 1, 32'h9876_0000);
        run_op(1, 1, 1, 1, 2'd2, 1, 32'h40, 32'h5555_AAAA, 5'd4, 2, 32'hCAFE_F00D);

        // Clear while waiting for an ack.
        @(posedge clk); #1;
        mvalid = 1; mwreg = 1; mm2reg = 1; mwmem = 0; msize = 2'd2; malu = 32'h300; d_ack = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("clr_pre_req", 32'(d_req), 32'h1);
        @(posedge clk); #1;
        clr = 1'b1; mvalid = 0;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_eq("clr_req", 32'(d_req), 32'h0);
        check_eq("clr_stall", 32'(mstall), 32'h0);
        @(posedge clk); #1;
        d_ack = 1'b1; d_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        d_ack = 1'b0;
        @(negedge clk);
        check_eq("late_ack_req", 32'(d_req), 32'h0);
        check_eq("late_ack_mmo", mmo, 32'h0);
        check_eq("late_ack_owreg", 32'(owreg), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[1:0] = 2'($urandom_range(0, 3));
            run_op(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
